// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shared constants, state encoding and count saturation helper
package shift_sequencer_pkg;
    localparam int WIDTH     = 16;
    localparam int CNT_W     = 5;
    localparam int MAX_SHIFT = 16;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : c;
    endfunction
endpackage

// File: rtl/shift_sequencer_shiftreg16.sv
// shiftreg16: 16-bit parallel-load register with logical single-bit left/right shift
module shiftreg16
    import shift_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             a_rst,
    input  logic             load_enable,
    input  logic             shift_enable,
    input  logic             left_right,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out
);
    always_ff @(posedge clk or posedge a_rst)
        if (a_rst)
            parallel_out <= '0;
        else if (load_enable)
            parallel_out <= parallel_in;
        else if (shift_enable)
            parallel_out <= left_right ? {parallel_out[WIDTH-2:0], 1'b0}
                                       : {1'b0, parallel_out[WIDTH-1:1]};
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven load/shift controller wrapped around shiftreg16
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             a_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_left,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);
    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] rem;
    logic             dir;
    logic [WIDTH-1:0] word;
    logic             load_enable, shift_enable, left_right;

    always_ff @(posedge clk or negedge a_rst_n)
        if (!a_rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = cmd_valid ? S_LOAD : S_IDLE;
            S_LOAD:  state_nx = abort ? S_IDLE : (rem != '0) ? S_SHIFT : S_DONE;
            S_SHIFT: state_nx = abort ? S_IDLE : (rem == CNT_W'(1)) ? S_DONE : S_SHIFT;
            S_DONE:  state_nx = res_ready ? S_IDLE : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // abort suppresses the enable in its own cycle so the register keeps its partial value
    always_comb begin
        cmd_ready    = state == S_IDLE;
        busy         = state != S_IDLE;
        res_valid    = state == S_DONE;
        load_enable  = state == S_LOAD && !abort;
        shift_enable = state == S_SHIFT && !abort;
        left_right   = dir;
    end

    always_ff @(posedge clk or negedge a_rst_n)
        if (!a_rst_n) begin
            rem  <= '0;
            dir  <= 1'b0;
            word <= '0;
        end else if (state == S_IDLE && cmd_valid) begin
            rem  <= sat_count(cmd_count);
            dir  <= cmd_left;
            word <= cmd_data;
        end else if (shift_enable) begin
            rem  <= rem - CNT_W'(1);
        end

    shiftreg16 u_shiftreg (
        .clk          (clk),
        .a_rst        (~a_rst_n),
        .load_enable  (load_enable),
        .shift_enable (shift_enable),
        .left_right   (left_right),
        .parallel_in  (word),
        .parallel_out (res_data)
    );
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vectors with hand-computed expectations for shift_sequencer
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        a_rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_left = 1'b0, abort = 1'b0;
    logic [15:0] cmd_data = '0, res_data;
    logic [4:0]  cmd_count = '0;
    logic        res_valid, res_ready = 1'b1, busy;
    int          total = 0, bad = 0;
    int          lat, loads, shifts, lr_bad, busy_bad;

    shift_sequencer dut (
        .clk       (clk),
        .a_rst_n   (a_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .cmd_left  (cmd_left),
        .abort     (abort),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // accepts at edge T; lat = cycle offset at which res_valid is first seen
    task automatic run_cmd(input logic [15:0] d, input logic [4:0] c, input logic l);
        cmd_data = d; cmd_count = c; cmd_left = l; cmd_valid = 1'b1;
        step;
        cmd_valid = 1'b0;
        lat = 1; loads = 0; shifts = 0; lr_bad = 0; busy_bad = 0;
        while (!res_valid && lat < 60) begin
            if (busy !== 1'b1) busy_bad++;
            if (dut.load_enable && dut.shift_enable) lr_bad++;
            loads  += int'(dut.load_enable);
            shifts += int'(dut.shift_enable);
            if (dut.shift_enable && dut.left_right !== l) lr_bad++;
            step;
            lat++;
        end
        if (busy !== 1'b1) busy_bad++;
    endtask

    initial begin
        #1 a_rst_n = 1'b0;
        #1;
        chk("rst_res_data", 32'(res_data), 32'h0);
        step; step;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #2 a_rst_n = 1'b1;
        step;

        run_cmd(16'h00F0, 5'd4, 1'b1);
        chk("t1_lat", 32'(lat), 32'd6);
        chk("t1_data", 32'(res_data), 32'h0F00);
        chk("t1_shifts", 32'(shifts), 32'd4);
        chk("t1_loads", 32'(loads), 32'd1);
        chk("t1_busy", 32'(busy_bad), 32'd0);
        step;
        chk("t1_idle_ready", 32'(cmd_ready), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        run_cmd(16'h8001, 5'd3, 1'b0);
        chk("t2_lat", 32'(lat), 32'd5);
        chk("t2_data", 32'(res_data), 32'h1000);
        chk("t2_shifts", 32'(shifts), 32'd3);
        chk("t2_dir", 32'(lr_bad), 32'd0);
        step;

        run_cmd(16'hA5A5, 5'd0, 1'b1);
        chk("t3_lat", 32'(lat), 32'd2);
        chk("t3_data", 32'(res_data), 32'hA5A5);
        chk("t3_shifts", 32'(shifts), 32'd0);
        chk("t3_loads", 32'(loads), 32'd1);
        step;

        run_cmd(16'hFFFF, 5'd20, 1'b1);
        chk("t4_lat", 32'(lat), 32'd18);
        chk("t4_data", 32'(res_data), 32'h0000);
        chk("t4_shifts", 32'(shifts), 32'd16);
        step;

        res_ready = 1'b0;
        run_cmd(16'h0001, 5'd1, 1'b1);
        chk("t5_lat", 32'(lat), 32'd3);
        cmd_data = 16'h1234; cmd_count = 5'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", 32'(res_valid), 32'd1);
            chk("t5_hold_data", 32'(res_data), 32'h0002);
            chk("t5_hold_ready", 32'(cmd_ready), 32'd0);
            step;
        end
        res_ready = 1'b1;
        step;
        chk("t5_release_valid", 32'(res_valid), 32'd0);
        chk("t5_release_ready", 32'(cmd_ready), 32'd1);
        step;
        cmd_valid = 1'b0;
        chk("t5_second_busy", 32'(busy), 32'd1);
        step;
        chk("t5_second_valid", 32'(res_valid), 32'd1);
        chk("t5_second_data", 32'(res_data), 32'h1234);
        step;

        cmd_data = 16'h00FF; cmd_count = 5'd8; cmd_left = 1'b1; cmd_valid = 1'b1;
        step;
        cmd_valid = 1'b0;
        step;
        step;
        chk("t6_in_shift", 32'(dut.shift_enable), 32'd1);
        abort = 1'b1;
        step;
        abort = 1'b0;
        chk("t6_abort_busy", 32'(busy), 32'd0);
        chk("t6_abort_ready", 32'(cmd_ready), 32'd1);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            lat += int'(res_valid) + int'(dut.shift_enable) + int'(dut.load_enable);
            step;
        end
        chk("t6_abort_quiet", 32'(lat), 32'd0);

        cmd_data = 16'h0055; cmd_count = 5'd0; cmd_valid = 1'b1; abort = 1'b1;
        step;
        cmd_valid = 1'b0; abort = 1'b0;
        chk("t6_idle_abort_accept", 32'(busy), 32'd1);
        res_ready = 1'b0;
        step;
        abort = 1'b1;
        step;
        chk("t6_done_valid", 32'(res_valid), 32'd1);
        chk("t6_done_data", 32'(res_data), 32'h0055);
        step;
        chk("t6_done_abort_ignored", 32'(res_valid), 32'd1);
        abort = 1'b0; res_ready = 1'b1;
        step;
        chk("t6_done_exit", 32'(res_valid), 32'd0);

        cmd_data = 16'hF0F0; cmd_count = 5'd8; cmd_left = 1'b0; cmd_valid = 1'b1;
        step;
        cmd_valid = 1'b0;
        step; step;
        chk("t6_rst_in_shift", 32'(busy), 32'd1);
        #2 a_rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
        chk("t6_rst_valid", 32'(res_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_data", 32'(res_data), 32'h0000);
        step;
        a_rst_n = 1'b1;
        step;
        chk("t6_post_rst_valid", 32'(res_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
